// File: rtl/enc_pkg.sv
// Shared types and elaboration helpers for the request-vector priority encoder.
package enc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Ceiling log2 for parameter sizing; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 32'd0) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Mirrors the low 'width' bits of code; bits at and above 'width' are returned as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] code, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (32'(i) < width) r[i] = code[5'(width - 1 - 32'(i))];
    end
    return r;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit encoder with an exactly-one-bit-set flag.
module lsb_prio_enc
  import enc_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned W_CODE = clog2(N_IN)
) (
  input  logic [N_IN-1:0]   i_vec,
  output logic [W_CODE-1:0] o_idx,
  output logic              o_onehot
);

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W_CODE'(i);
    end
  end

  assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - N_IN'(1))) == '0);

endmodule

// File: rtl/req_vec_encoder.sv
// Serialises a multi-hot request vector into one binary index beat per set bit,
// lowest index first, over valid/ready handshakes on both sides.
module req_vec_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned W_CODE       = clog2(N_IN),
  parameter bit          REVERSE_CODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_IN-1:0]   req_vec,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [W_CODE-1:0] code,
  output logic              code_last,
  output logic              zero_err,
  output logic              busy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [N_IN-1:0]     r_pend;
  logic [N_IN-1:0]     w_pend_nxt;
  logic [W_CODE-1:0]   w_idx;
  logic                w_onehot;
  logic [W_CODE-1:0]   w_code_nxt;
  logic                w_last_nxt;
  logic                w_zero_err_nxt;

  logic                r_req_ready;
  logic                r_code_valid;
  logic [W_CODE-1:0]   r_code;
  logic                r_code_last;
  logic                r_zero_err;
  logic                r_busy;

  // Encodes the pending set as it will be after this edge, so code/code_last can be registered.
  lsb_prio_enc #(
    .N_IN   (N_IN),
    .W_CODE (W_CODE)
  ) u_lsb_prio_enc (
    .i_vec    (w_pend_nxt),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    w_zero_err_nxt = 1'b0;
    w_code_nxt     = '0;
    w_last_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          if (req_vec != '0) begin
            w_pend_nxt  = req_vec;
            w_state_nxt = EMIT;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        // Accepted beat: drop the lowest pending bit.
        if (code_ready) begin
          w_pend_nxt = r_pend & (r_pend - N_IN'(1));
          if (r_code_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == EMIT) begin
      w_code_nxt = REVERSE_CODE ? W_CODE'(bit_reverse(32'(w_idx), W_CODE)) : w_idx;
      w_last_nxt = w_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_code_valid <= 1'b0;
      r_code       <= '0;
      r_code_last  <= 1'b0;
      r_zero_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= (w_state_nxt == IDLE);
      r_code_valid <= (w_state_nxt == EMIT);
      r_code       <= w_code_nxt;
      r_code_last  <= w_last_nxt;
      r_zero_err   <= w_zero_err_nxt;
      r_busy       <= (w_state_nxt == EMIT);
    end
  end

  assign req_ready  = r_req_ready;
  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign code_last  = r_code_last;
  assign zero_err   = r_zero_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_req_vec_encoder.sv
// Self-checking bench: normal and bit-reversed encoders driven in lockstep, checked
// against a queue of expected indices built from the request vector's set bits.
module tb_req_vec_encoder;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_vec;
  logic       code_ready;

  logic       req_ready,   req_ready_r;
  logic       code_valid,  code_valid_r;
  logic [1:0] code,        code_r;
  logic       code_last,   code_last_r;
  logic       zero_err,    zero_err_r;
  logic       busy,        busy_r;

  int n_checks;
  int n_errors;

  req_vec_encoder #(.N_IN(4), .REVERSE_CODE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .code_valid(code_valid), .code_ready(code_ready),
    .code(code), .code_last(code_last), .zero_err(zero_err), .busy(busy)
  );

  req_vec_encoder #(.N_IN(4), .REVERSE_CODE(1'b1)) u_dut_rev (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_r),
    .req_vec(req_vec), .code_valid(code_valid_r), .code_ready(code_ready),
    .code(code_r), .code_last(code_last_r), .zero_err(zero_err_r), .busy(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rev2(input int i);
    return ((i & 1) << 1) | ((i >> 1) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_req_ready_rev"}, req_ready_r, 1);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_code_valid_rev"}, code_valid_r, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_busy_rev"}, busy_r, 0);
  endtask

  // Present a vector and complete the request handshake.
  task automatic accept(input logic [3:0] vec);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_vec   = vec;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_vec   = 4'($urandom);
  endtask

  // Expect one beat per set bit, ascending; mode 0 always ready, 1 random stalls, 2 three initial stalls.
  task automatic drain(input logic [3:0] vec, input int mode);
    int q[$];
    int cyc;
    logic rdy;
    for (int i = 0; i < 4; i++) if (vec[i]) q.push_back(i);
    cyc = 0;
    while (q.size() > 0 && cyc < 64) begin
      chk("code_valid", code_valid, 1);
      chk("code_valid_rev", code_valid_r, 1);
      chk("busy", busy, 1);
      chk("req_ready_emit", req_ready, 0);
      chk("code", code, q[0]);
      chk("code_rev", code_r, rev2(q[0]));
      chk("code_last", code_last, (q.size() == 1));
      chk("code_last_rev", code_last_r, (q.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (cyc >= 3);
      endcase
      code_ready = rdy;
      tick();
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    chk("drain_timeout", q.size(), 0);
    code_ready = 1'b0;
    check_idle("post_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_vec    = '0;
    code_ready = 1'b0;

    #12;
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_code_last", code_last, 0);
    chk("rst_zero_err", zero_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code_rev", code_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("rst_release");

    accept(4'b1011);
    drain(4'b1011, 0);

    accept(4'b0110);
    drain(4'b0110, 0);

    accept(4'b0101);
    drain(4'b0101, 2);

    accept(4'b0000);
    chk("zero_err_pulse", zero_err, 1);
    chk("zero_err_pulse_rev", zero_err_r, 1);
    chk("zero_no_valid", code_valid, 0);
    chk("zero_req_ready", req_ready, 1);
    tick();
    chk("zero_err_clear", zero_err, 0);
    chk("zero_no_valid2", code_valid, 0);
    chk("zero_req_ready2", req_ready, 1);

    // Asynchronous reset in the middle of an all-ones vector.
    accept(4'b1111);
    code_ready = 1'b1;
    chk("ones_beat0", code, 0);
    tick();
    chk("ones_beat1", code, 1);
    tick();
    chk("ones_beat2", code, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_code_valid", code_valid, 0);
    chk("midrst_code_valid_rev", code_valid_r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_code", code, 0);
    chk("midrst_code_last", code_last, 0);
    code_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("midrst_release");
    accept(4'b1000);
    drain(4'b1000, 0);

    // New vector held valid through EMIT is taken only once back in IDLE.
    req_valid = 1'b1;
    req_vec   = 4'b0011;
    tick();
    req_vec   = 4'b1100;
    drain(4'b0011, 0);
    tick();
    req_valid = 1'b0;
    drain(4'b1100, 0);

    for (int n = 0; n < 40; n++) begin
      v = 4'($urandom_range(0, 15));
      accept(v);
      if (v == 4'b0000) begin
        chk("rand_zero_err", zero_err, 1);
        chk("rand_zero_no_valid", code_valid, 0);
        tick();
        chk("rand_zero_err_clear", zero_err, 0);
      end else begin
        drain(v, $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
